// File: rtl/pdm_pkg.sv
// pdm_pkg: shared PDM constants, CIC width and thermometer helpers
package pdm_pkg;

    localparam int SAMPLE_W = 10;

    function automatic int cic_width(input int log2_r);
        return 2 * log2_r + 1;
    endfunction

    function automatic logic [15:0] thermo16(input logic [SAMPLE_W-1:0] level);
        logic [4:0] k;
        k = 5'(({1'b0, level} + 11'd63) >> 6);
        return 16'((17'd1 << ((k > 5'd16) ? 5'd16 : k)) - 17'd1);
    endfunction

endpackage

// File: rtl/pdm_decimator_cic2.sv
// cic2_decim: 2nd-order CIC decimator with free-running integrators and comb warm-up
module cic2_decim
    import pdm_pkg::*;
#(
    parameter int LOG2_R = 6,
    localparam int W = cic_width(LOG2_R)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         b,
    output logic [W-1:0] c2,
    output logic         tick,
    output logic         primed
);

    logic [W-1:0]      i1, i2, d1, d2, c1;
    logic [LOG2_R-1:0] cnt;
    logic [1:0]        warm;

    assign tick   = &cnt;
    assign c1     = i2 - d1;
    assign c2     = c1 - d2;
    assign primed = warm[1];

    // integrators run every clk; modulo wrap cancels out in the combs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            i1 <= '0;
            i2 <= '0;
        end else begin
            i1 <= i1 + W'(b);
            i2 <= i2 + i1;
        end

    // decimation counter, tick on its last count
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + 1'b1;

    // comb delays load on tick; first two ticks only prime them
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            d1   <= '0;
            d2   <= '0;
            warm <= '0;
        end else if (tick) begin
            d1 <= i2;
            d2 <= c1;
            if (!primed) warm <= warm + 2'd1;
        end

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM pin to 10-bit amplitude (sync, CIC2, scaling); optional LEVEL_METER_EN peak-hold LED bar
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int LOG2_R    = 6,
    parameter int OUT_W     = SAMPLE_W,
    parameter int LOG2_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic [15:0]      led_bar
);

    localparam int W  = cic_width(LOG2_R);
    localparam int SH = 2 * LOG2_R - OUT_W;
    localparam logic [W-1:0] FULL = W'(1) << (2 * LOG2_R);

    if (LOG2_R < 5 || LOG2_R > 10 || OUT_W != SAMPLE_W || LOG2_HOLD < 1) begin : g_bad_params
        $error("pdm_decimator: illegal parameters");
    end

    logic [1:0]   sync;
    logic [W-1:0] c2;
    logic         tick, primed;

    // two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], pdm_in};

    cic2_decim #(.LOG2_R(LOG2_R)) u_cic (
        .clk    (clk),
        .rst_n  (rst_n),
        .b      (sync[1]),
        .c2     (c2),
        .tick   (tick),
        .primed (primed)
    );

    // scale to OUT_W on tick; full scale R^2 clamps to all ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick && primed;
            if (tick && primed) sample_out <= (c2 == FULL) ? '1 : OUT_W'(c2 >> SH);
        end

`ifdef LEVEL_METER_EN
    logic [OUT_W-1:0]     peak, peak_next;
    logic [LOG2_HOLD-1:0] hold_cnt;

    assign peak_next = (sample_out > peak) ? sample_out : peak;

    // track the window peak and refresh the bar once per window
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            peak     <= '0;
            hold_cnt <= '0;
            led_bar  <= '0;
        end else if (sample_valid) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (&hold_cnt) begin
                led_bar <= thermo16(peak_next);
                peak    <= sample_out;
            end else begin
                peak <= peak_next;
            end
        end
`else
    assign led_bar = '0;
`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: scoreboard bench for pdm_decimator with directed PDM patterns
module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pdm_in;
    logic [9:0]  sample_out;
    logic        sample_valid;
    logic [15:0] led_bar;

    pdm_decimator #(.LOG2_R(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pdm_in       (pdm_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .led_bar      (led_bar)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        bit first;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   passed = 0;
    int   since;
    int   last_at = 0;
    bit   prev_valid = 1'b0;
    int   mode = 0;
    bit   jitter = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    // clk edges since the last reset release
    always @(posedge clk or negedge rst_n)
        if (!rst_n) since <= 0;
        else        since <= since + 1;

    // PDM source: 0 / 1 / alternating, optionally changing at random points between edges
    initial begin
        pdm_in = 1'b0;
        forever begin
            @(posedge clk);
            #(jitter ? $urandom_range(1, 9) : 5);
            pdm_in = (mode == 2) ? ~pdm_in : (mode == 1);
        end
    end

    // monitor: pop and compare on every strobe
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sample_valid === 1'b1) begin
            check("back-to-back strobe", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected strobe: sample_out=%0d at cycle %0d, none expected", sample_out, since);
            end else begin
                cur = sb.pop_front();
                check("sample_out", int'(sample_out), cur.value);
                if (cur.first) check("first strobe cycle", since, 192);
                else           check("strobe spacing", since - last_at, 64);
`ifndef LEVEL_METER_EN
                check("led_bar", int'(led_bar), 0);
`endif
            end
            last_at = since;
        end
        prev_valid = (sample_valid === 1'b1);
    end

    task automatic do_reset(input int m);
        mode = m;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sample_out", int'(sample_out), 0);
        check("reset sample_valid", int'(sample_valid), 0);
        check("reset led_bar", int'(led_bar), 0);
        rst_n = 1'b1;
    endtask

    task automatic expect_n(input int v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.value = v;
            e.first = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d strobes missing after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        do_reset(1);
        expect_n(1023, 4);
        drain(600);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset sample_out", int'(sample_out), 0);
        check("async reset sample_valid", int'(sample_valid), 0);
        #9 rst_n = 1'b1;
        expect_n(1023, 3);
        drain(600);
        do_reset(0);
        expect_n(0, 3);
        drain(600);
        do_reset(2);
        expect_n(512, 4);
        drain(600);
        jitter = 1'b1;
        do_reset(2);
        expect_n(512, 3);
        drain(600);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Receive side of the synth's 1-bit PDM output (`dout`). Recovers a 10-bit unsigned amplitude sample from a pin-level PDM stream.
- Uses a 2-stage synchroniser, a 2nd-order CIC decimator and output scaling.
- Sits between a breakout input pin and the LED16 display or downstream logic, so a looped-back `F32` signal can be measured on-board.

Parameters:
- LOG2_R, 6, log2 of decimation ratio R (R = 64). Legal range 5..10.
- OUT_W, 10, output sample width. Fixed at 10 to match the synth amplitude range.
- LOG2_HOLD, 4, log2 of the peak-hold window in output samples. Used only with LEVEL_METER_EN.

Ports:
- clk  input  1  system clock (48 MHz HFOSC); one PDM bit per clk
- rst_n  input  1  asynchronous active-low reset
- pdm_in  input  1  raw PDM bit from pin; asynchronous to clk
- sample_out  output  OUT_W  decoded amplitude, 0..1023
- sample_valid  output  1  one-cycle strobe; sample_out is new this cycle
- led_bar  output  16  thermometer level display (LEVEL_METER_EN only)

Behaviour:
- Reset (rst_n low, asynchronous assert, release synchronous to clk):
  - sync flops, integrators, comb delays, decimation counter and warm-up counter all clear to 0.
  - sample_out = 0, sample_valid = 0, led_bar = 0.
  - Reset mid-operation discards all partial accumulation.
- Synchroniser: two flops; bit b = second flop output. pdm_in-to-integrator latency is 2 cycles.
- Accumulator width W = 2*LOG2_R+1 bits, unsigned.
  - i1 <= i1 + b; i2 <= i2 + i1, every clk.
  - Both wrap modulo 2^W. Wrap is intentional (CIC property); no saturation in integrators.
- Decimation counter cnt: LOG2_R bits, increments every clk, wraps R-1 -> 0. tick = (cnt == R-1).
- On tick, combs are evaluated combinationally from the current i2, modulo 2^W:
  - c1 = i2 - d1; c2 = c1 - d2.
  - Then d1 <= i2, d2 <= c1.
- Result c2 lies in 0..R^2.
- Scaling, registered on tick:
  - if c2 == R^2: sample_out <= 1023
  - else: sample_out <= c2 >> (2*LOG2_R - 10)
- sample_valid is asserted the cycle after tick, with sample_out already updated. Exactly one strobe per R cycles; never two consecutive high cycles.
- Warm-up: the first 2 ticks after reset update the comb delays but do not update sample_out and do not assert sample_valid. The first strobe follows the 3rd tick.
- Steady-state group delay: about 2 decimation periods plus 3 clk.
- Input toggling at any rate is legal; pdm_in has no X-propagation dependence beyond the synchroniser.

Optional Feature:
- Macro LEVEL_METER_EN.
- Defined:
  - peak register holds the max sample_out over a window of 2^LOG2_HOLD valid samples.
  - At window end, led_bar <= thermometer with k = min(16, (peak+63)>>6) low bits set. peak then restarts from the current sample.
  - Examples: 0 -> 0x0000; 1023 -> 0xFFFF; 512 -> 0x00FF.
- Undefined: led_bar is tied to 0 and the peak logic is absent. The port list is unchanged.

Decomposition:
- Shared package pdm_pkg holds:
  - localparam SAMPLE_W = 10
  - function cic_width(log2_r)
  - the thermometer encoder function
  - these are shared with the synth-side PDM modulator.
- One natural sub-module: cic2_decim (integrators, counter, combs, warm-up). The top adds the synchroniser, scaling and the optional meter.

Test Plan:
- pdm_in held 1 from reset, LOG2_R=6 -> first sample_valid on the cycle after the 3rd tick, with sample_out = 1023; every strobe after that also gives 1023, spaced exactly 64 cycles.
- pdm_in held 0 -> every strobe gives sample_out = 0; LEVEL_METER_EN build gives led_bar = 0x0000.
- pdm_in alternating 1,0 per clk -> steady sample_out = 512; with LEVEL_METER_EN, led_bar = 0x00FF after 16 samples.
- Feed the synth PDM output at amp 1023 with a 2 Hz saw -> sample_out ramps monotonically (within ±2 LSB per step) and wraps once per 500 ms. Integrator wrap causes no glitches.
- rst_n pulsed low for 1 cycle mid-window (asynchronous edge, not clk-aligned) -> outputs are 0 immediately; warm-up repeats, with 2 ticks suppressed before the next valid strobe.
- pdm_in toggled between clk edges (asynchronous jitter) -> no X on outputs; decoded value is still 512 ±1 for a 50% density pattern.
